// File: rtl/servo_pkg.sv
// servo_pkg: shared servo constants and ramp FSM state encoding
//   MIN_PW / MAX_PW : pulse width limits in clk cycles (0 deg / 180 deg)
//   PW_PER_DEG      : clk cycles added per degree
//   MAX_DEG         : largest accepted angle, larger commands are clamped
//   PW_WIDTH        : bit width of pulse-width arithmetic
package servo_pkg;
    localparam int MIN_PW     = 50_000;
    localparam int MAX_PW     = 240_000;
    localparam int PW_PER_DEG = 1055;
    localparam int MAX_DEG    = 180;
    localparam int PW_WIDTH   = 18;
    typedef enum logic [1:0] {IDLE, CALC, RAMP} state_t;
endpackage

// File: rtl/servo_tick_gen.sv
// servo_tick_gen: free-running ramp tick generator
//   clk  : system clock
//   rst  : asynchronous active-high reset, clears the counter
//   tick : high for one cycle every RAMP_DIV cycles (when count = RAMP_DIV-1)
module servo_tick_gen #(
    parameter int RAMP_DIV = 2048
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = $clog2(RAMP_DIV);
    logic [CW-1:0] r_cnt;
    assign tick = r_cnt == CW'(RAMP_DIV - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cnt <= '0;
        else     r_cnt <= tick ? '0 : r_cnt + 1'b1;
    end
endmodule

// File: rtl/servo_ramp_ctrl.sv
// servo_ramp_ctrl: angle command to rate-limited servo pulse width
//   clk, rst    : system clock, asynchronous active-high reset
//   angle_in    : commanded angle in degrees, clamped to MAX_DEG
//   angle_valid : angle_in valid this cycle
//   angle_ready : command accepted this cycle (low only while computing a target)
//   pw_out      : current pulse width in clk cycles
//   busy        : pw_out has not yet settled on the target
//   done        : one-cycle pulse when the target is reached
module servo_ramp_ctrl
    import servo_pkg::*;
#(
    parameter int MIN_PW     = servo_pkg::MIN_PW,
    parameter int MAX_PW     = servo_pkg::MAX_PW,
    parameter int PW_PER_DEG = servo_pkg::PW_PER_DEG,
    parameter int RAMP_DIV   = 2048,
    parameter int RAMP_STEP  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          angle_in,
    input  logic                angle_valid,
    output logic                angle_ready,
    output logic [PW_WIDTH-1:0] pw_out,
    output logic                busy,
    output logic                done
);
    localparam logic [PW_WIDTH-1:0] PW_MIN  = PW_WIDTH'(MIN_PW);
    localparam logic [PW_WIDTH-1:0] PW_MAX  = PW_WIDTH'(MAX_PW);
    localparam logic [PW_WIDTH-1:0] PW_STEP = PW_WIDTH'(RAMP_STEP);

    state_t              r_state;
    logic [7:0]          r_angle;
    logic [PW_WIDTH-1:0] r_target;
    logic [PW_WIDTH-1:0] r_pw;
    logic                r_done;
    logic                w_tick;
    logic                w_xfer;
    logic [7:0]          w_angle;
    logic [PW_WIDTH-1:0] w_calc;
    logic [PW_WIDTH-1:0] w_new;
    logic [PW_WIDTH-1:0] w_diff;

    servo_tick_gen #(.RAMP_DIV(RAMP_DIV)) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(w_tick)
    );

    assign w_xfer  = angle_valid && angle_ready;
    assign w_angle = (angle_in > 8'(MAX_DEG)) ? 8'(MAX_DEG) : angle_in;
    assign w_calc  = PW_MIN + PW_WIDTH'(r_angle) * PW_WIDTH'(PW_PER_DEG);
    assign w_new   = (w_calc > PW_MAX) ? PW_MAX : (w_calc < PW_MIN) ? PW_MIN : w_calc;
    assign w_diff  = (r_target > r_pw) ? r_target - r_pw : r_pw - r_target;

    assign angle_ready = r_state != CALC;
    assign busy        = r_state != IDLE;
    assign done        = r_done;
    assign pw_out      = r_pw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_angle  <= '0;
            r_target <= PW_MIN;
            r_pw     <= PW_MIN;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (w_xfer) begin
                    r_angle <= w_angle;
                    r_state <= CALC;
                end
                CALC: begin
                    r_target <= w_new;
                    if (w_new != r_pw) r_state <= RAMP;
                    else begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
                RAMP: begin
                    // a retarget wins over both completion and a coincident tick
                    if (w_xfer) begin
                        r_angle <= w_angle;
                        r_state <= CALC;
                    end else if (r_pw == r_target) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end else if (w_tick)
                        r_pw <= (w_diff <= PW_STEP) ? r_target :
                                (r_target > r_pw) ? r_pw + PW_STEP : r_pw - PW_STEP;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// tb_servo_ramp_ctrl: directed self-checking bench for servo_ramp_ctrl
module tb_servo_ramp_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  angle_in = '0;
    logic        angle_valid = 1'b0;
    logic        angle_ready;
    logic [17:0] pw_out;
    logic        busy;
    logic        done;
    int tests = 0;
    int fails = 0;
    int changes, ndone, last_delta, bad;

    always #5 clk = ~clk;

    servo_ramp_ctrl #(.RAMP_DIV(4), .RAMP_STEP(1000)) dut (
        .clk        (clk),
        .rst        (rst),
        .angle_in   (angle_in),
        .angle_valid(angle_valid),
        .angle_ready(angle_ready),
        .pw_out     (pw_out),
        .busy       (busy),
        .done       (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic send(input logic [7:0] a);
        angle_in    = a;
        angle_valid = 1'b1;
        step();
        angle_valid = 1'b0;
    endtask

    // follows a ramp to completion; counts pw changes, done pulses, bad steps
    task automatic run_ramp(input string tag, input int dir, output int n_chg,
                            output int n_done, output int last, output int n_bad);
        int prev = int'(pw_out);
        int fin = 0;
        n_chg = 0; n_done = 0; last = 0; n_bad = 0;
        for (int c = 0; c < 2000; c++) begin
            step();
            if (int'(pw_out) != prev) begin
                last = int'(pw_out) - prev;
                n_chg++;
                if (last * dir <= 0 || last * dir > 1000) n_bad++;
                prev = int'(pw_out);
            end
            if (done) n_done++;
            if (!busy) begin
                fin = 1;
                break;
            end
        end
        chk({tag, "_finished"}, fin, 1);
        step();
        if (done) n_done++;
    endtask

    task automatic wait_pw(input string tag, input logic [17:0] v, output int n_done);
        int hit = 0;
        n_done = 0;
        for (int c = 0; c < 2000; c++) begin
            if (pw_out == v) begin
                hit = 1;
                break;
            end
            step();
            if (done) n_done++;
        end
        chk({tag, "_reached"}, hit, 1);
    endtask

    initial begin
        repeat (3) step();
        chk("rst_pw", pw_out, 50_000);
        chk("rst_busy", busy, 0);
        chk("rst_ready", angle_ready, 1);
        chk("rst_done", done, 0);

        rst = 1'b0;
        send(8'd0);
        chk("a0_calc_busy", busy, 1);
        chk("a0_calc_ready", angle_ready, 0);
        step();
        chk("a0_done", done, 1);
        chk("a0_idle_busy", busy, 0);
        chk("a0_pw", pw_out, 50_000);
        step();
        chk("a0_done_once", done, 0);

        send(8'd90);
        chk("a90_calc_ready", angle_ready, 0);
        step();
        chk("a90_ramp_ready", angle_ready, 1);
        chk("a90_ramp_busy", busy, 1);
        chk("a90_hold", pw_out, 50_000);
        run_ramp("a90", 1, changes, ndone, last_delta, bad);
        chk("a90_ticks", changes, 95);
        chk("a90_last_step", last_delta, 950);
        chk("a90_bad_steps", bad, 0);
        chk("a90_done_count", ndone, 1);
        chk("a90_pw", pw_out, 144_950);

        send(8'd250);
        run_ramp("a250", 1, changes, ndone, last_delta, bad);
        chk("a250_pw", pw_out, 239_900);
        chk("a250_ticks", changes, 95);
        chk("a250_done_count", ndone, 1);

        rst = 1'b1;
        step();
        chk("rst2_pw", pw_out, 50_000);
        rst = 1'b0;

        send(8'd180);
        wait_pw("rev", 18'd100_000, ndone);
        chk("rev_no_early_done", ndone, 0);
        send(8'd0);
        chk("rev_calc_pw", pw_out, 100_000);
        chk("rev_calc_ready", angle_ready, 0);
        chk("rev_calc_done", done, 0);
        run_ramp("rev", -1, changes, ndone, last_delta, bad);
        chk("rev_ticks", changes, 50);
        chk("rev_bad_steps", bad, 0);
        chk("rev_done_count", ndone, 1);
        chk("rev_pw", pw_out, 50_000);

        send(8'd180);
        wait_pw("abort", 18'd120_000, ndone);
        #3 rst = 1'b1;
        #1;
        chk("abort_pw", pw_out, 50_000);
        chk("abort_busy", busy, 0);
        chk("abort_ready", angle_ready, 1);
        step();
        rst = 1'b0;
        ndone = 0;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (done) ndone++;
            if (busy || pw_out != 18'd50_000) bad++;
        end
        chk("abort_no_done", ndone, 0);
        chk("abort_stays_idle", bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
